pipe_phy_ctrl: RTL
==================

PIPE_PHY_CTRL -- requirements
Module: pipe_phy_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: cycles phy_status stays high after reset deasserts.
REQ-002 SHALL have parameter PD_LATENCY, default 8: cycles from power_down change to phy_status pulse.
REQ-003 SHALL have parameter RATE_LATENCY, default 32: cycles from rate change to phy_status pulse.
REQ-004 SHALL have parameter DETECT_LATENCY, default 12: cycles from tx_detect_rx rise to phy_status pulse.
REQ-005 SHALL have ports: clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 power_down  in  4  MAC-requested state: 0=P0, 1=P0s, 2=P1, 3=P2; other values ignored.
REQ-008 rate  in  4  MAC-requested rate code.
REQ-009 tx_detect_rx  in  1  receiver-detect request (level).
REQ-010 rx_present  in  1  bench/config: far-end receiver present.
REQ-011 phy_status  out  1  PIPE PhyStatus.
REQ-012 rx_status  out  3  PIPE RxStatus.
REQ-013 rx_elec_idle  out  1  PIPE RxElecIdle.
REQ-014 cur_power_down  out  4  power state in effect.
REQ-015 cur_rate  out  4  rate in effect.
REQ-016 busy  out  1  high whenever FSM is not in IDLE.

Function
REQ-017 FSM states: RST_HOLD, IDLE, PD_WAIT, RATE_WAIT, DET_WAIT, ACK.
REQ-018 RST_HOLD: phy_status=1; one down-counter loaded with RESET_CYCLES-1; at zero -> IDLE, phy_status=0 next cycle.
REQ-019 IDLE: requests evaluated each cycle, priority power_down change > rate change > detect.
REQ-020 Power change: valid power_down (0..3) != cur_power_down -> PD_WAIT, counter=PD_LATENCY-1; at zero cur_power_down updates to latched request -> ACK.
REQ-021 Rate change: rate != cur_rate -> RATE_WAIT, counter=RATE_LATENCY-1; at zero cur_rate updates -> ACK.
REQ-022 Detect: tx_detect_rx rising (vs registered previous value) while cur_power_down==P1 -> DET_WAIT, counter=DETECT_LATENCY-1, rx_present sampled at counter zero -> ACK.
REQ-023 tx_detect_rx rise in any state other than P1, or outside IDLE, SHALL be ignored (no pulse).
REQ-024 ACK: phy_status=1 for exactly one cycle, then IDLE.
REQ-025 rx_status SHALL be 3'b011 during a detect ACK with rx_present=1 sampled, else 3'b000 always.
REQ-026 Requests SHALL be latched on FSM entry; input changes during PD_WAIT/RATE_WAIT/DET_WAIT ignored; a still-differing level is re-evaluated in IDLE after ACK (one new transaction, new latency).
REQ-027 Total latency: request-visible cycle in IDLE to phy_status pulse = LATENCY+1 cycles.
REQ-028 rx_elec_idle SHALL be 0 only when cur_power_down==P0 and rx_present==1; 1 otherwise.
REQ-029 Counters SHALL be wide enough for max(all latency parameters); parameters SHALL be >=1.

Reset
REQ-030 On reset=1 (any state, mid-transaction): FSM->RST_HOLD, phy_status=1, rx_status=0, rx_elec_idle=1, cur_power_down=P1 (2), cur_rate=0, busy=1, pending latches cleared.
REQ-031 Counter restarts at RESET_CYCLES-1 only after reset deasserts; reset asserted again during RST_HOLD reloads it.

Structure
REQ-032 pipe_agent_pkg SHALL hold the power-state enum (P0/P0S/P1/P2), FSM state enum, and RX_STATUS_DETECTED=3'b011 constant.
REQ-033 One sub-module, pipe_phy_lat_cnt (loadable down-counter with zero flag), SHALL be shared by all wait states.
REQ-034 Outputs SHALL connect directly to pipe_if signals of the same name (cur_* internal to the agent).

Verification
REQ-035 Release reset at cycle 0 -> phy_status high cycles 0..15, low at 16; cur_power_down=2, cur_rate=0.
REQ-036 In P1 set power_down=0 -> phy_status pulses exactly once 9 cycles later; cur_power_down=0; rx_elec_idle=0 if rx_present=1.
REQ-037 Change power_down 3 and rate 1 in same cycle -> power ACK first (9 cycles), then rate ACK 33 cycles after return to IDLE.
REQ-038 In P1, tx_detect_rx rise, rx_present=1 -> one-cycle phy_status with rx_status=3'b011 13 cycles later; rx_present=0 -> rx_status=0; in P0 -> no pulse.
REQ-039 Assert reset mid RATE_WAIT -> next cycle phy_status=1, cur_rate=0, no rate ACK ever emitted.
REQ-040 Toggle rate during RATE_WAIT back and forth -> only final differing level triggers a second transaction after first ACK.

Source files
------------

// File: rtl/pipe_agent_pkg.sv
// Shared types for the PIPE PHY control agent: power states, FSM states, RxStatus codes.
// Also holds the elaboration-time helpers used to size the shared latency counter.
package pipe_agent_pkg;

  typedef enum logic [3:0] {
    P0  = 4'd0,
    P0S = 4'd1,
    P1  = 4'd2,
    P2  = 4'd3
  } pwr_state_t;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    PD_WAIT,
    RATE_WAIT,
    DET_WAIT,
    ACK
  } phy_state_t;

  localparam logic [2:0] RX_STATUS_DETECTED = 3'b011;
  localparam logic [2:0] RX_STATUS_NONE     = 3'b000;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Bits needed to hold max_val-1 (the largest value ever loaded), never less than 1.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) < max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/pipe_phy_lat_cnt.sv
// Loadable down-counter with a zero flag; one instance is shared by every wait state.
// Load has priority over decrement; decrement saturates at zero.
module pipe_phy_lat_cnt #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pipe_phy_ctrl.sv
// PIPE PHY-side control FSM: reset hold, power-state / rate changes and receiver detect,
// each acknowledged with a one-cycle phy_status pulse after a parameterised latency.
module pipe_phy_ctrl
  import pipe_agent_pkg::*;
#(
  parameter int RESET_CYCLES   = 16,
  parameter int PD_LATENCY     = 8,
  parameter int RATE_LATENCY   = 32,
  parameter int DETECT_LATENCY = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] power_down,
  input  logic [3:0] rate,
  input  logic       tx_detect_rx,
  input  logic       rx_present,
  output logic       phy_status,
  output logic [2:0] rx_status,
  output logic       rx_elec_idle,
  output logic [3:0] cur_power_down,
  output logic [3:0] cur_rate,
  output logic       busy
);

  localparam int MAX_LAT = max4(RESET_CYCLES, PD_LATENCY, RATE_LATENCY, DETECT_LATENCY);
  localparam int CW      = cnt_width(MAX_LAT);

  localparam logic [CW-1:0] RST_LD  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] PD_LD   = CW'(PD_LATENCY - 1);
  localparam logic [CW-1:0] RATE_LD = CW'(RATE_LATENCY - 1);
  localparam logic [CW-1:0] DET_LD  = CW'(DETECT_LATENCY - 1);

  phy_state_t state, state_nxt;
  pwr_state_t cur_pd, pd_req;
  logic [3:0] rate_cur, rate_req;
  logic       det_prev;
  logic       det_hit;

  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_dec;
  logic          cnt_zero;
  logic          pd_latch;
  logic          rate_latch;

  logic pd_change;
  logic rate_change;
  logic det_rise;

  // Reserved power_down encodings (4..15) never start a transaction.
  assign pd_change   = (power_down <= 4'd3) && (power_down != cur_pd);
  assign rate_change = (rate != rate_cur);
  assign det_rise    = tx_detect_rx && !det_prev;

  pipe_phy_lat_cnt #(
    .WIDTH (CW)
  ) u_lat_cnt (
    .clk      (clk),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt  = state;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    pd_latch   = 1'b0;
    rate_latch = 1'b0;

    case (state)
      RST_HOLD: begin
        if (cnt_zero) state_nxt = IDLE;
        else          cnt_dec   = 1'b1;
      end
      IDLE: begin
        if (pd_change) begin
          state_nxt = PD_WAIT;
          cnt_load  = 1'b1;
          cnt_val   = PD_LD;
          pd_latch  = 1'b1;
        end else if (rate_change) begin
          state_nxt  = RATE_WAIT;
          cnt_load   = 1'b1;
          cnt_val    = RATE_LD;
          rate_latch = 1'b1;
        end else if (det_rise && (cur_pd == P1)) begin
          state_nxt = DET_WAIT;
          cnt_load  = 1'b1;
          cnt_val   = DET_LD;
        end
      end
      PD_WAIT, RATE_WAIT, DET_WAIT: begin
        if (cnt_zero) state_nxt = ACK;
        else          cnt_dec   = 1'b1;
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = RST_HOLD;
      end
    endcase

    // Every reset cycle reloads the hold count, so the full hold restarts on release.
    if (reset) begin
      cnt_load = 1'b1;
      cnt_val  = RST_LD;
      cnt_dec  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RST_HOLD;
      cur_pd   <= P1;
      pd_req   <= P1;
      rate_cur <= '0;
      rate_req <= '0;
      det_prev <= 1'b0;
      det_hit  <= 1'b0;
    end else begin
      state    <= state_nxt;
      det_prev <= tx_detect_rx;

      if (pd_latch)   pd_req   <= pwr_state_t'(power_down);
      if (rate_latch) rate_req <= rate;

      if ((state == PD_WAIT) && cnt_zero)   cur_pd   <= pd_req;
      if ((state == RATE_WAIT) && cnt_zero) rate_cur <= rate_req;

      // Detect result only lives for the ACK it belongs to.
      if ((state == DET_WAIT) && cnt_zero) det_hit <= rx_present;
      else if (state == ACK)               det_hit <= 1'b0;
    end
  end

  assign phy_status     = (state == RST_HOLD) || (state == ACK);
  assign rx_status      = ((state == ACK) && det_hit) ? RX_STATUS_DETECTED : RX_STATUS_NONE;
  assign rx_elec_idle   = !((cur_pd == P0) && rx_present);
  assign cur_power_down = cur_pd;
  assign cur_rate       = rate_cur;
  assign busy           = (state != IDLE);

endmodule
